padlock_input_conditioner: RTL and testbench
============================================

Name: padlock_input_conditioner

Overview:
- Front-end stage that sits directly upstream of the padlock core.
- Takes raw, bouncy, asynchronous pushbutton and switch inputs: three code keys, clear and program.
- Delivers synchronized, debounced levels and single-cycle press events, which the padlock core consumes as its key, clear and program inputs.
- Also flags illegal multi-key presses so the core or its top level can ignore them.

Parameters:
- N_KEYS, 3, number of code keys.
- SYNC_STAGES, 2, flip-flops in each input synchronizer chain; minimum 2.
- DB_COUNT, 50000, consecutive cycles a synchronized input must differ from its debounced value before that value flips; minimum 1.
- DB_WIDTH, 16, width of each debounce counter; must satisfy 2^DB_WIDTH >= DB_COUNT.

Ports:
- clk  in  1  single system clock; every register is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_raw  in  N_KEYS  raw code-key buttons, active high.
- clr_raw  in  1  raw clear button, active high.
- prog_raw  in  1  raw program-mode switch, active high.
- key_level  out  N_KEYS  debounced key levels.
- key_pulse  out  N_KEYS  one-cycle press event per key.
- key_valid  out  1  one-cycle strobe: exactly one legal key press.
- key_idx  out  2  index of the pressed key; qualified by key_valid.
- key_conflict  out  1  one-cycle strobe: illegal multi-key press.
- clr_level  out  1  debounced clear level.
- clr_pulse  out  1  one-cycle clear press event.
- prog_level  out  1  debounced program level.
- prog_toggle  out  1  one-cycle strobe on any debounced prog change.

Behaviour:
- Interface (decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset: all synchronizer flops, debounce counters, debounced levels and output registers clear to 0. Every output is 0 during reset and in the first cycle after it.
- Channels: N_KEYS+2 identical channels (keys, clr, prog), each a SYNC_STAGES synchronizer, a DB_WIDTH counter and a debounced level register.
- Debounce, at each clk edge:
  - If synced == level: counter <= 0.
  - Otherwise, if counter == DB_COUNT-1: level <= synced and counter <= 0.
  - Otherwise: counter <= counter+1.
  - Any return of synced to level before the flip discards the partial count; glitches shorter than DB_COUNT cycles never propagate.
- Latency:
  - A raw change that is stable from edge 1 changes the level at edge SYNC_STAGES+DB_COUNT.
  - Registered event outputs assert one edge later and hold exactly one cycle.
- key_pulse[i] / clr_pulse: registered rising-edge detect of the debounced level. A release produces no pulse.
- prog_toggle: registered either-edge detect of prog_level.
- Key encoding, registered and evaluated on the same cycle as key_pulse:
  - Set P = keys whose pulse is being generated; set H = other keys whose level is already high.
  - |P|==1 and H empty: key_valid=1, key_idx = index.
  - |P|>=1 and (|P|>1 or H non-empty): key_conflict=1, key_valid=0, key_idx=0.
  - Clear dominates: if clr_level is high when the key pulse is generated, key_valid=0 and key_conflict=0. key_pulse still fires.
  - When key_valid=0, key_idx=0.
- Held through reset: a button high at reset release is seen as a fresh press after SYNC_STAGES+DB_COUNT+1 cycles.
- Reset mid-operation: all partial counts and pending pulses are discarded immediately. No event is emitted on reset release except by the held-through-reset rule.
- DB_COUNT=1: the level follows synced one edge later.
- Counter never wraps: it is bounded by DB_COUNT-1.

Test Plan (DB_COUNT=4, SYNC_STAGES=2):
- Reset: assert rst mid-stream with key_raw=3'b010 -> all outputs 0 immediately. After release with key still held, key_pulse=3'b010, key_valid=1, key_idx=1 exactly 7 edges later.
- Clean press: key_raw[2] rises and holds -> key_level[2] high at edge 6. key_pulse[2], key_valid=1, key_idx=2 for the single cycle after edge 7. No pulse on release.
- Bounce: key_raw[0] toggles 1,1,1,0,1,1,0 then holds 1 -> exactly one key_pulse[0], 7 edges after the final stable rise. A 3-cycle glitch alone produces nothing.
- Conflict: key 0 held (level high), then key 1 pressed -> key_pulse[1]=1, key_conflict=1, key_valid=0. Keys 0 and 2 raised in the same cycle -> both pulses, key_conflict=1.
- Clear dominance: clr held, then key 1 pressed -> clr_pulse once, key_pulse[1]=1, key_valid=0, key_conflict=0.
- Program: prog_raw 0->1 and later 1->0 -> prog_toggle one cycle each, 7 edges after each change. prog_level follows at edge 6.

Source files
------------

// File: rtl/padlock_input_conditioner.sv
// Input conditioner for the padlock core: synchronizes and debounces the
// raw key, clear and program inputs, then turns the debounced levels into
// single-cycle events and a one-hot key decode with conflict detection.
module padlock_input_conditioner #(
    parameter int N_KEYS      = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DB_COUNT    = 50000,
    parameter int DB_WIDTH    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic              clr_raw,
    input  logic              prog_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_pulse,
    output logic              key_valid,
    output logic [1:0]        key_idx,
    output logic              key_conflict,
    output logic              clr_level,
    output logic              clr_pulse,
    output logic              prog_level,
    output logic              prog_toggle
);

    // Channel layout: keys occupy the low bits, then clear, then program.
    localparam int NCH     = N_KEYS + 2;
    localparam int CLR_CH  = N_KEYS;
    localparam int PROG_CH = N_KEYS + 1;
    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_COUNT - 1);

    logic [NCH-1:0]      raw_bus;
    logic [NCH-1:0]      sync_p0 [SYNC_STAGES];
    logic [NCH-1:0]      synced_p0;
    logic [DB_WIDTH-1:0] db_cnt_p1 [NCH];
    logic [NCH-1:0]      level_p1;
    logic [NCH-1:0]      level_p2;

    logic [NCH-1:0]      rise_p1;
    logic [N_KEYS-1:0]   key_rise_p1;
    logic [N_KEYS-1:0]   key_held_p1;
    logic                key_valid_nx;
    logic                key_conflict_nx;
    logic [1:0]          key_idx_nx;

    // Number of keys set in a vector; used to tell single presses from chords.
    function automatic int count_ones(input logic [N_KEYS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    assign raw_bus   = {prog_raw, clr_raw, key_raw};
    assign synced_p0 = sync_p0[SYNC_STAGES-1];

    // ---- stage p0: metastability synchronizer chain per channel ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_p0[s] <= '0;
            end
        end else begin
            sync_p0[0] <= raw_bus;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_p0[s] <= sync_p0[s-1];
            end
        end
    end

    // ---- stage p1: debounce; level flips only after DB_COUNT differing cycles ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_p1 <= '0;
            for (int c = 0; c < NCH; c++) begin
                db_cnt_p1[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (synced_p0[c] == level_p1[c]) begin
                    db_cnt_p1[c] <= '0;
                end else if (db_cnt_p1[c] == DB_LAST) begin
                    level_p1[c]  <= synced_p0[c];
                    db_cnt_p1[c] <= '0;
                end else begin
                    db_cnt_p1[c] <= db_cnt_p1[c] + DB_WIDTH'(1);
                end
            end
        end
    end

    // Edge detection compares the current debounced level with its previous value.
    assign rise_p1     = level_p1 & ~level_p2;
    assign key_rise_p1 = rise_p1[N_KEYS-1:0];
    assign key_held_p1 = level_p1[N_KEYS-1:0] & level_p2[N_KEYS-1:0];

    // Key decode: a lone press with no other key held is legal; clear suppresses both strobes.
    always_comb begin
        key_valid_nx    = 1'b0;
        key_conflict_nx = 1'b0;
        key_idx_nx      = 2'd0;
        if (!level_p1[CLR_CH] && (count_ones(key_rise_p1) >= 1)) begin
            if ((count_ones(key_rise_p1) == 1) && (key_held_p1 == '0)) begin
                key_valid_nx = 1'b1;
                for (int i = 0; i < N_KEYS; i++) begin
                    if (key_rise_p1[i]) key_idx_nx = 2'(i);
                end
            end else begin
                key_conflict_nx = 1'b1;
            end
        end
    end

    // ---- stage p2: registered events and level history ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_p2     <= '0;
            key_pulse    <= '0;
            key_valid    <= 1'b0;
            key_idx      <= 2'd0;
            key_conflict <= 1'b0;
            clr_pulse    <= 1'b0;
            prog_toggle  <= 1'b0;
        end else begin
            level_p2     <= level_p1;
            key_pulse    <= key_rise_p1;
            key_valid    <= key_valid_nx;
            key_idx      <= key_idx_nx;
            key_conflict <= key_conflict_nx;
            clr_pulse    <= rise_p1[CLR_CH];
            prog_toggle  <= level_p1[PROG_CH] ^ level_p2[PROG_CH];
        end
    end

    assign key_level  = level_p1[N_KEYS-1:0];
    assign clr_level  = level_p1[CLR_CH];
    assign prog_level = level_p1[PROG_CH];

endmodule

// File: tb/tb_padlock_input_conditioner.sv
// Scoreboard bench for padlock_input_conditioner with DB_COUNT=4, SYNC_STAGES=2.
module tb_padlock_input_conditioner;

    localparam int N_KEYS      = 3;
    localparam int SYNC_STAGES = 2;
    localparam int DB_COUNT    = 4;
    localparam int DB_WIDTH    = 16;
    localparam int LAT         = SYNC_STAGES + DB_COUNT + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_KEYS-1:0] key_raw = '0;
    logic              clr_raw = 1'b0;
    logic              prog_raw = 1'b0;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_pulse;
    logic              key_valid;
    logic [1:0]        key_idx;
    logic              key_conflict;
    logic              clr_level;
    logic              clr_pulse;
    logic              prog_level;
    logic              prog_toggle;

    padlock_input_conditioner #(
        .N_KEYS(N_KEYS), .SYNC_STAGES(SYNC_STAGES),
        .DB_COUNT(DB_COUNT), .DB_WIDTH(DB_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw), .clr_raw(clr_raw),
        .prog_raw(prog_raw), .key_level(key_level), .key_pulse(key_pulse),
        .key_valid(key_valid), .key_idx(key_idx), .key_conflict(key_conflict),
        .clr_level(clr_level), .clr_pulse(clr_pulse), .prog_level(prog_level),
        .prog_toggle(prog_toggle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [8:0] ev;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    wire [8:0]  ev_now = {key_pulse, key_valid, key_idx, key_conflict, clr_pulse, prog_toggle};
    wire [13:0] outs   = {key_level, key_pulse, key_valid, key_idx, key_conflict,
                          clr_level, clr_pulse, prog_level, prog_toggle};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0] mk(input logic [2:0] p, input logic v, input logic [1:0] i,
                                      input logic c, input logic cp, input logic pt);
        return {p, v, i, c, cp, pt};
    endfunction

    task automatic push(input int c, input logic [8:0] ev, input string name);
        exp_t e;
        e.cyc = c;
        e.ev = ev;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: every cycle with an active event strobe consumes one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ev_now !== 9'd0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_event", 32'(ev_now), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_cycle"}, cyc, e.cyc);
                    check({e.name, "_outputs"}, 32'(ev_now), 32'(e.ev));
                end
            end
        end
    end

    // Stimulus: inputs change on falling edges; expectations are pushed with their cycle.
    initial begin
        int t0;
        int t1;
        logic bseq [7];
        bseq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        check("reset_state", 32'(outs), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first_cycle_after_reset", 32'(outs), 32'd0);
        repeat (3) @(negedge clk);

        // Reset mid-stream with key 1 held through it
        key_raw = 3'b010;
        t0 = cyc;
        wait_until(t0 + 5);
        check("rst_key_level_edge5", 32'(key_level), 32'd0);
        wait_until(t0 + 6);
        check("rst_key_level_edge6", 32'(key_level), 32'b010);
        rst = 1'b1;
        #1;
        check("reset_midstream_outputs", 32'(outs), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        push(t0 + LAT, mk(3'b010, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0), "held_through_reset");
        @(negedge clk);
        check("post_release_outputs", 32'(outs), 32'd0);
        wait_until(t0 + 12);
        key_raw = 3'b000;
        wait_until(cyc + 12);

        // Clean press of key 2, then release without a pulse
        key_raw = 3'b100;
        t0 = cyc;
        push(t0 + LAT, mk(3'b100, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0), "clean_press");
        wait_until(t0 + 5);
        check("clean_level_edge5", 32'(key_level), 32'd0);
        wait_until(t0 + 6);
        check("clean_level_edge6", 32'(key_level), 32'b100);
        wait_until(t0 + 12);
        key_raw = 3'b000;
        t1 = cyc;
        wait_until(t1 + 6);
        check("release_level", 32'(key_level), 32'd0);
        wait_until(t1 + 12);

        // Bouncing key 0 settles high: one pulse counted from the final rise
        for (int i = 0; i < 7; i++) begin
            key_raw[0] = bseq[i];
            @(negedge clk);
        end
        key_raw[0] = 1'b1;
        t0 = cyc;
        push(t0 + LAT, mk(3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), "bounce_press");
        wait_until(t0 + 12);
        key_raw = 3'b000;
        wait_until(cyc + 12);

        // A three-cycle glitch alone never reaches the level
        key_raw[0] = 1'b1;
        repeat (3) @(negedge clk);
        key_raw[0] = 1'b0;
        t0 = cyc;
        wait_until(t0 + 10);
        check("glitch_level", 32'(key_level), 32'd0);

        // Key 0 held, then key 1 pressed: conflict
        key_raw = 3'b001;
        t0 = cyc;
        push(t0 + LAT, mk(3'b001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0), "key0_hold");
        wait_until(t0 + 10);
        key_raw = 3'b011;
        t1 = cyc;
        push(t1 + LAT, mk(3'b010, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0), "conflict_held");
        wait_until(t1 + 10);
        key_raw = 3'b000;
        wait_until(cyc + 12);

        // Keys 0 and 2 pressed together: conflict with both pulses
        key_raw = 3'b101;
        t0 = cyc;
        push(t0 + LAT, mk(3'b101, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0), "conflict_simul");
        wait_until(t0 + 10);
        key_raw = 3'b000;
        wait_until(cyc + 12);

        // Clear held, then key 1: pulse fires but no valid or conflict
        clr_raw = 1'b1;
        t0 = cyc;
        push(t0 + LAT, mk(3'b000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0), "clr_press");
        wait_until(t0 + 10);
        key_raw = 3'b010;
        t1 = cyc;
        push(t1 + LAT, mk(3'b010, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0), "key_under_clr");
        wait_until(t1 + 10);
        clr_raw = 1'b0;
        key_raw = 3'b000;
        wait_until(cyc + 12);

        // Program switch: toggle strobe on both edges
        prog_raw = 1'b1;
        t0 = cyc;
        push(t0 + LAT, mk(3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1), "prog_rise");
        wait_until(t0 + 5);
        check("prog_level_rise_edge5", 32'(prog_level), 32'd0);
        wait_until(t0 + 6);
        check("prog_level_rise_edge6", 32'(prog_level), 32'd1);
        wait_until(t0 + 12);
        prog_raw = 1'b0;
        t1 = cyc;
        push(t1 + LAT, mk(3'b000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1), "prog_fall");
        wait_until(t1 + 5);
        check("prog_level_fall_edge5", 32'(prog_level), 32'd1);
        wait_until(t1 + 6);
        check("prog_level_fall_edge6", 32'(prog_level), 32'd0);
        wait_until(t1 + 12);

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
